// File: rtl/bus_pkg.sv
// Shared definitions for the PE-array bus blocks: default widths, the
// source-index width helper and the zero-mask broadcast convention.
package bus_pkg;

    localparam int unsigned DEF_NUM_PES   = 4;
    localparam int unsigned DEF_NUM_SRCS  = 2;
    localparam int unsigned DEF_DATA_TYPE = 16;

    // An all-zero destination mask addresses every PE.
    localparam bit ZERO_MASK_IS_BCAST = 1'b1;

    // Index width for n sources, never narrower than one bit.
    function automatic int unsigned src_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_multicast_arb_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps; the pointer
// moves past the winner whenever the grant is taken (advance).
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned N = DEF_NUM_SRCS,
    parameter int unsigned W = src_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] ptr;

    function automatic int unsigned wrap_idx(input int unsigned p, input int unsigned i);
        int unsigned s;
        s = p + i;
        return (s >= N) ? s - N : s;
    endfunction

    // First requesting source at or after the pointer.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt_onehot == '0 && req[wrap_idx(32'(ptr), i)]) begin
                gnt_onehot[wrap_idx(32'(ptr), i)] = 1'b1;
                gnt_idx = W'(wrap_idx(32'(ptr), i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (32'(gnt_idx) >= N - 1) ? '0 : W'(32'(gnt_idx) + 1);
        end
    end

endmodule

// File: rtl/bus_multicast_arb.sv
// Arbitrated multicast bus: one held output word delivered to a per-transfer
// PE subset with per-PE valid/ready. BUS_MULTICAST_STATS_EN adds counters.
module bus_multicast_arb
    import bus_pkg::*;
#(
    parameter int unsigned NUM_PES   = DEF_NUM_PES,
    parameter int unsigned NUM_SRCS  = DEF_NUM_SRCS,
    parameter int unsigned DATA_TYPE = DEF_DATA_TYPE,
    parameter int unsigned SRC_W     = src_w(NUM_SRCS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRCS-1:0]           req,
    input  logic [NUM_SRCS*DATA_TYPE-1:0] data_in,
    input  logic [NUM_SRCS*NUM_PES-1:0]   dest_mask,
    output logic [NUM_SRCS-1:0]           grant,
    output logic [NUM_PES*DATA_TYPE-1:0]  data_out,
    output logic [NUM_PES-1:0]            valid_out,
    input  logic [NUM_PES-1:0]            ready_in,
    output logic                          busy
`ifdef BUS_MULTICAST_STATS_EN
    ,
    output logic [31:0]                   xfer_cnt,
    output logic [31:0]                   stall_cnt
`endif
);

    logic [DATA_TYPE-1:0] data_reg;
    logic [NUM_SRCS-1:0]  arb_onehot;
    logic [SRC_W-1:0]     arb_idx;
    logic                 capture;
    logic [NUM_PES-1:0]   win_mask;
    logic [NUM_PES-1:0]   load_mask;
    logic [NUM_PES-1:0]   pend_nxt;
    logic [DATA_TYPE-1:0] win_data;

    rr_arbiter #(
        .N (NUM_SRCS),
        .W (SRC_W)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .advance    (capture),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx)
    );

    // Stage is free when nothing is owed after this cycle's acceptances.
    always_comb begin
        capture   = (|req) && ((valid_out & ~ready_in) == '0);
        win_data  = data_in[32'(arb_idx)*DATA_TYPE +: DATA_TYPE];
        win_mask  = dest_mask[32'(arb_idx)*NUM_PES +: NUM_PES];
        load_mask = (ZERO_MASK_IS_BCAST && win_mask == '0) ? '1 : win_mask;
        pend_nxt  = capture ? load_mask : (valid_out & ~ready_in);
    end

    // valid_out is the pending set itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_out <= '0;
            busy      <= 1'b0;
            grant     <= '0;
            data_reg  <= '0;
        end else begin
            valid_out <= pend_nxt;
            busy      <= |pend_nxt;
            grant     <= capture ? arb_onehot : '0;
            if (capture) begin
                data_reg <= win_data;
            end
        end
    end

    assign data_out = {NUM_PES{data_reg}};

`ifdef BUS_MULTICAST_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (capture) begin
                xfer_cnt <= xfer_cnt + 32'd1;
            end
            if (busy && ((valid_out & ~ready_in) != '0)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_multicast_arb.sv
// Directed bench for bus_multicast_arb (2 sources, 4 PEs, 16-bit words);
// the counter checks are built when BUS_MULTICAST_STATS_EN is defined.
module tb_bus_multicast_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] data_in;
    logic [7:0]  dest_mask;
    logic [1:0]  grant;
    logic [63:0] data_out;
    logic [3:0]  valid_out;
    logic [3:0]  ready_in;
    logic        busy;
`ifdef BUS_MULTICAST_STATS_EN
    logic [31:0] xfer_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_multicast_arb #(
        .NUM_PES   (4),
        .NUM_SRCS  (2),
        .DATA_TYPE (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .dest_mask (dest_mask),
        .grant     (grant),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .busy      (busy)
`ifdef BUS_MULTICAST_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] g, input logic [3:0] v,
                             input logic b, input logic [15:0] d);
        check({tag, ".grant"}, 64'(grant), 64'(g));
        check({tag, ".valid"}, 64'(valid_out), 64'(v));
        check({tag, ".busy"},  64'(busy), 64'(b));
        check({tag, ".data"},  data_out, {4{d}});
    endtask

    initial begin
        rst_n = 1'b0; req = '0; data_in = '0; dest_mask = '0; ready_in = '0;
        #2;
        step(); step();
        check_out("reset", 2'b00, 4'h0, 1'b0, 16'h0000);

        // Single broadcast from src0.
        rst_n = 1'b1; req = 2'b01; data_in = {16'h0000, 16'hA5A5}; ready_in = 4'hF;
        step();
        check_out("single", 2'b01, 4'hF, 1'b1, 16'hA5A5);
        req = 2'b00;
        step();
        check_out("single_drain", 2'b00, 4'h0, 1'b0, 16'hA5A5);

        // Both hold req: pointer is at src1 after the src0 grant.
        req = 2'b11; data_in = {16'h2222, 16'h1111};
        step(); check_out("rr0", 2'b10, 4'hF, 1'b1, 16'h2222);
        step(); check_out("rr1", 2'b01, 4'hF, 1'b1, 16'h1111);
        step(); check_out("rr2", 2'b10, 4'hF, 1'b1, 16'h2222);
        step(); check_out("rr3", 2'b01, 4'hF, 1'b1, 16'h1111);
        req = 2'b00;
        step(); check_out("rr_drain", 2'b00, 4'h0, 1'b0, 16'h1111);

        // Multicast 0101, PE2 stalls three cycles while src1 waits.
        req = 2'b01; data_in = {16'hCAFE, 16'hBEEF}; dest_mask = {4'b1010, 4'b0101};
        ready_in = 4'b0001;
        step(); check_out("mc_cap", 2'b01, 4'b0101, 1'b1, 16'hBEEF);
        req = 2'b10;
        step(); check_out("mc_hold1", 2'b00, 4'b0100, 1'b1, 16'hBEEF);
        step(); check_out("mc_hold2", 2'b00, 4'b0100, 1'b1, 16'hBEEF);
        step(); check_out("mc_hold3", 2'b00, 4'b0100, 1'b1, 16'hBEEF);

        // Final accept and src1 capture on the same edge.
        ready_in = 4'hF;
        step(); check_out("b2b", 2'b10, 4'b1010, 1'b1, 16'hCAFE);

        // src0 multicast 1010, then reset mid-transfer.
        req = 2'b01; data_in = {16'h0000, 16'h1234}; dest_mask = {4'b0000, 4'b1010};
        step(); check_out("pre_rst", 2'b01, 4'b1010, 1'b1, 16'h1234);
        rst_n = 1'b0; req = 2'b00; ready_in = 4'h0;
        step(); check_out("mid_rst", 2'b00, 4'h0, 1'b0, 16'h0000);

        // Pointer back at src0 after reset.
        rst_n = 1'b1; req = 2'b11; data_in = {16'h6666, 16'h5555}; dest_mask = '0;
        ready_in = 4'hF;
        step(); check_out("post_rst", 2'b01, 4'hF, 1'b1, 16'h5555);
        req = 2'b00;
        step(); check_out("post_rst_drain", 2'b00, 4'h0, 1'b0, 16'h5555);

`ifdef BUS_MULTICAST_STATS_EN
        rst_n = 1'b0;
        step();
        check("stats_rst_xfer",  64'(xfer_cnt),  64'd0);
        check("stats_rst_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1; req = 2'b01; data_in = {16'h0000, 16'h7777};
        dest_mask = {4'b0000, 4'b0011}; ready_in = 4'b0001;
        step();
        req = 2'b00;
        step(); step(); step(); step();
        check("stats_mid_stall", 64'(stall_cnt), 64'd4);
        ready_in = 4'hF; req = 2'b01; dest_mask = '0;
        step(); step(); step(); step();
        req = 2'b00;
        step();
        check("stats_xfer",  64'(xfer_cnt),  64'd5);
        check("stats_stall", 64'(stall_cnt), 64'd4);
        check("stats_idle",  64'(busy),      64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
